// File: rtl/log_mag_pkg.sv
// log_mag_pkg: shared types and width helpers for the log-magnitude pipeline.
//   mode_e     : per-sample post-processing selector (value 3 behaves as MODE_INST)
//   exp_w()    : bits needed for the MSB index of a (2*IN_W+1)-bit sum
//   out_w()    : width of the fixed-point log2 result
//   ch_w()     : channel tag width, never below 1
//   lut_entry(): one entry of the log2 fraction table, evaluated at elaboration
package log_mag_pkg;

  typedef enum logic [1:0] {
    MODE_INST = 2'd0,
    MODE_PEAK = 2'd1,
    MODE_AVG  = 2'd2
  } mode_e;

  function automatic int exp_w(input int in_w);
    return $clog2(2 * in_w + 1);
  endfunction

  function automatic int out_w(input int in_w, input int frac_w);
    return exp_w(in_w) + frac_w;
  endfunction

  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // round(2^fw * log2(1 + k/2^aw)), saturated to fw bits. The log is taken
  // bit by bit with repeated squaring of a Q1.31 mantissa: every time the
  // square reaches 2 the next binary digit of the log is 1. 24 digits leave
  // plenty of margin below the rounding point. Valid for aw <= 31, fw <= 23.
  function automatic int lut_entry(input int k, input int aw, input int fw);
    longint unsigned x;
    int              bits;
    int              rnd;
    x    = (64'd1 << 31) + (64'(k) << (31 - aw));
    bits = 0;
    for (int i = 0; i < 24; i++) begin
      x    = (x * x) >> 31;
      bits = bits << 1;
      if (x >= (64'd1 << 32)) begin
        bits = bits | 1;
        x    = x >> 1;
      end
    end
    rnd = (bits + (1 << (23 - fw))) >> (24 - fw);
    if (rnd > (1 << fw) - 1) rnd = (1 << fw) - 1;
    return rnd;
  endfunction

endpackage

// File: rtl/msb_find.sv
// msb_find: priority encoder returning the index of the highest set bit.
//   din  : vector to search
//   idx  : index of the most significant 1 (0 when din is zero)
//   zero : din is all zeros
module msb_find #(
  parameter int W  = 33,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  din,
  output logic [IW-1:0] idx,
  output logic          zero
);

  always_comb begin
    // NOTE: idx gets a default before the loop so every path assigns it and
    // no latch is inferred; blocking '=' is right here because later loop
    // iterations must see (and override) earlier ones.
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (din[i]) idx = IW'(i);
    end
  end

  assign zero = ~|din;

endmodule

// File: rtl/log_mag_pipe.sv
// log_mag_pipe: four-stage log2(x^2+y^2) pipeline over time-multiplexed
// channels, with per-channel peak hold and exponential averaging.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake; in_x/in_y signed I/Q, in_ch tag
//   mode                 : 0/3 instant, 1 peak hold, 2 exp average (read in S4)
//   clear                : one-cycle strobe zeroing all channel state
//   out_valid/out_ready  : output handshake
//   out_log              : unsigned log2 result, FRAC_W fraction bits
//   out_ch, out_zero     : channel tag and zero-magnitude flag of the result
module log_mag_pipe
  import log_mag_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int CH       = 4,
  parameter int FRAC_W   = 4,
  parameter int LUT_AW   = 8,
  parameter int AVG_SH   = 2,
  parameter     LUT_FILE = "log2_frac_lut.mem"
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [IN_W-1:0]         in_x,
  input  logic signed [IN_W-1:0]         in_y,
  input  logic [ch_w(CH)-1:0]            in_ch,
  input  logic [1:0]                     mode,
  input  logic                           clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [out_w(IN_W, FRAC_W)-1:0] out_log,
  output logic [ch_w(CH)-1:0]            out_ch,
  output logic                           out_zero
);

  localparam int SQ_W  = 2 * IN_W;
  localparam int SUM_W = 2 * IN_W + 1;
  localparam int EXP_W = exp_w(IN_W);
  localparam int OUT_W = out_w(IN_W, FRAC_W);
  localparam int CH_W  = ch_w(CH);
  localparam int ACC_W = OUT_W + AVG_SH;

  // The fraction ROM is built at elaboration from the same formula that
  // produces the LUT_FILE image, so the block carries no file dependency.
  logic unused_lut_name;
  assign unused_lut_name = (LUT_FILE == "");

  logic [FRAC_W-1:0] lut_rom [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_lut
    localparam logic [FRAC_W-1:0] ENTRY = FRAC_W'(lut_entry(k, LUT_AW, FRAC_W));
    assign lut_rom[k] = ENTRY;
  end

  // One global enable: any output stall freezes every stage together.
  logic adv;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  // ---------------- stage registers ----------------
  logic              v1, v2, v3;
  logic [SQ_W-1:0]   sq1_x, sq1_y;
  logic [SUM_W-1:0]  sum2;
  logic [OUT_W-1:0]  l3;
  logic              z3;
  logic [CH_W-1:0]   ch1, ch2, ch3;

  logic signed [SQ_W-1:0] x_wide, y_wide;
  assign x_wide = SQ_W'(in_x);
  assign y_wide = SQ_W'(in_y);

  // S3 combinational: normalise the S2 sum and look up the fraction.
  logic [EXP_W-1:0]        e_s3;
  logic                    z_s3;
  logic [SUM_W+LUT_AW-1:0] norm;
  logic [LUT_AW-1:0]       m_s3;
  logic [OUT_W-1:0]        l_s3;

  msb_find #(.W(SUM_W), .IW(EXP_W)) u_msb_find (
    .din  (sum2),
    .idx  (e_s3),
    .zero (z_s3)
  );

  // Shifting the MSB to the top leaves the mantissa bits right below it; the
  // appended zeros supply the right-padding when fewer than LUT_AW bits exist.
  assign norm = {sum2, {LUT_AW{1'b0}}} << (EXP_W'(SUM_W - 1) - e_s3);
  assign m_s3 = norm[SUM_W+LUT_AW-2 -: LUT_AW];
  assign l_s3 = z_s3 ? '0 : {e_s3, lut_rom[m_s3]};

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking '<=' so every stage samples the values
    // its predecessor held before the edge.
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // NOTE: payload registers carry no reset; their stage valid already masks
  // them, which keeps the reset net off the wide datapath.
  always_ff @(posedge clk) begin
    if (adv) begin
      sq1_x <= x_wide * x_wide;
      sq1_y <= y_wide * y_wide;
      ch1   <= in_ch;
      sum2  <= {1'b0, sq1_x} + {1'b0, sq1_y};
      ch2   <= ch1;
      l3    <= l_s3;
      z3    <= z_s3;
      ch3   <= ch2;
    end
  end

  // ---------------- S4: mode apply ----------------
  logic [OUT_W-1:0] peak_q [CH];
  logic [ACC_W-1:0] acc_q  [CH];

  logic             in_rng;
  logic [CH_W-1:0]  ch_idx;
  logic [OUT_W-1:0] prior_peak, peak_new;
  logic [ACC_W-1:0] prior_acc, acc_new;
  logic [OUT_W-1:0] res;
  logic             upd_peak, upd_acc;
  mode_e            mode_s4;

  assign mode_s4    = mode_e'(mode);
  assign in_rng     = (int'(ch3) < CH);
  assign ch_idx     = in_rng ? ch3 : '0;
  // A coincident clear makes this sample start from empty state.
  assign prior_peak = clear ? '0 : peak_q[ch_idx];
  assign prior_acc  = clear ? '0 : acc_q[ch_idx];
  assign peak_new   = (l3 > prior_peak) ? l3 : prior_peak;
  assign acc_new    = prior_acc + ACC_W'(l3) - (prior_acc >> AVG_SH);
  assign upd_peak   = adv & v3 & in_rng & (mode_s4 == MODE_PEAK);
  assign upd_acc    = adv & v3 & in_rng & (mode_s4 == MODE_AVG);

  always_comb begin
    res = l3;
    if (in_rng) begin
      case (mode_s4)
        MODE_PEAK: res = peak_new;
        MODE_AVG:  res = acc_new[ACC_W-1:AVG_SH];
        default:   res = l3;
      endcase
    end
  end

  // NOTE: channel state is held in flops rather than RAM because it needs an
  // asynchronous reset and a single-cycle clear of every channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        peak_q[c] <= '0;
        acc_q[c]  <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CH; c++) begin
        peak_q[c] <= '0;
        acc_q[c]  <= '0;
      end
    end else begin
      if (upd_peak) peak_q[ch_idx] <= peak_new;
      if (upd_acc)  acc_q[ch_idx]  <= acc_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_log   <= '0;
      out_ch    <= '0;
      out_zero  <= 1'b0;
    end else if (adv) begin
      out_valid <= v3;
      if (v3) begin
        out_log  <= res;
        out_ch   <= ch3;
        out_zero <= z3;
      end
    end
  end

endmodule

// File: doc/log_mag_pipe.md
LOG_MAG_PIPE -- requirements
Module: log_mag_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, signed width of each I/Q component.
REQ-002 SHALL have parameter CH, default 4, number of time-multiplexed channels; CH_W = max(1, clog2(CH)).
REQ-003 SHALL have parameter FRAC_W, default 4, fractional bits of the log2 result.
REQ-004 SHALL have parameter LUT_AW, default 8, mantissa bits used to address the fraction LUT.
REQ-005 SHALL have parameter AVG_SH, default 2, averaging shift (alpha = 2^-AVG_SH).
REQ-006 SHALL have parameter LUT_FILE, default "log2_frac_lut.mem", hex LUT image with 2^LUT_AW entries of FRAC_W bits.
REQ-007 SHALL derive EXP_W = clog2(2*IN_W+1) and OUT_W = EXP_W+FRAC_W.
REQ-008 Ports, in order:
  clk        in   1        sole clock, rising edge
  rst        in   1        asynchronous, active-high reset
  in_valid   in   1        input sample valid
  in_ready   out  1        block can accept a sample
  in_x       in   IN_W     signed I component
  in_y       in   IN_W     signed Q component
  in_ch      in   CH_W     channel tag
  mode       in   2        0=instant, 1=peak hold, 2=exp average, 3=instant
  clear      in   1        one-cycle strobe; zeroes all per-channel state
  out_valid  out  1        result valid
  out_ready  in   1        downstream accepts result
  out_log    out  OUT_W    log2(x^2+y^2) in unsigned fixed point, FRAC_W fraction bits
  out_ch     out  CH_W     channel tag of result
  out_zero   out  1        x^2+y^2 was zero

Function
REQ-009 Transfer occurs on any clk edge with valid&ready high on that interface.
REQ-010 Four-stage pipeline: S1 squares, S2 sums (2*IN_W+1 bits, no overflow), S3 normalise+LUT, S4 mode apply/output register.
REQ-011 Latency SHALL be exactly 4 cycles from input transfer to out_valid when out_ready stays high.
REQ-012 Stall = out_valid & ~out_ready; all stages hold on stall; in_ready = ~stall; no sample is dropped or duplicated.
REQ-013 Throughput SHALL be one sample per cycle without stall; bubbles propagate as invalid stage entries.
REQ-014 S3: E = index of MSB of sum; M = next LUT_AW bits below MSB, zero-padded on the right when E < LUT_AW.
REQ-015 S3: L = E*2^FRAC_W + LUT[M]; LUT[k] = min(2^FRAC_W-1, round(2^FRAC_W*log2(1+k/2^LUT_AW))).
REQ-016 Sum zero: L = 0 and zero flag = 1; otherwise zero flag = 0.
REQ-017 Mode 0/3: out_log = L; channel state untouched.
REQ-018 Mode 1: state[ch] = max(state[ch], L); out_log = new state[ch].
REQ-019 Mode 2: acc[ch] (OUT_W+AVG_SH bits) += L - (acc[ch] >> AVG_SH); out_log = new acc[ch] >> AVG_SH.
REQ-020 Mode SHALL be sampled with each sample in S4; changing mode mid-stream affects only later samples.
REQ-021 Per-channel state SHALL be read and written only in S4, so back-to-back same-channel samples need no forwarding.
REQ-022 Clear SHALL zero all peak/acc state in the cycle it is high; if coincident with an S4 update, clear wins and that sample's output uses state = 0 as prior.
REQ-023 in_ch >= CH SHALL pass data in mode 0 behaviour and leave all state unchanged.
REQ-024 out_ch and out_zero SHALL travel aligned with their sample.

Reset
REQ-025 rst SHALL asynchronously clear all stage valids, out_valid, out_log, out_ch, out_zero and all channel state to 0.
REQ-026 in_ready SHALL be 1 while rst is high and after release.
REQ-027 Samples in flight when rst asserts SHALL be discarded.

Structure
REQ-028 Package log_mag_pkg SHALL hold the mode enum (MODE_INST, MODE_PEAK, MODE_AVG) and the EXP_W/OUT_W width functions.
REQ-029 Sub-module msb_find (parametric priority encoder returning index and zero flag) SHALL implement REQ-014 detection.

Verification
REQ-030 Mode 0, x=3, y=4 -> sum 25, E=4, M=144, out_log=74, out_zero=0, 4 cycles later.
REQ-031 x=-32768, y=-32768 -> sum 2^31, out_log=496; x=0,y=0 -> out_log=0, out_zero=1.
REQ-032 Mode 1 ch1: (3,4) then (1,0) -> outputs 74, 74; clear pulse, then (1,0) -> 0.
REQ-033 Mode 2 ch2, AVG_SH=2: (3,4) twice -> outputs 18, 32; ch0 state unaffected.
REQ-034 Continuous stream, out_ready low 3 cycles -> out_* stable, in_ready low, all samples in order, none lost.
REQ-035 rst asserted mid-stream -> outputs and state zero immediately; first post-reset sample gives REQ-030 result.
